// File: rtl/int_action_dispatch_pkg.sv
// Shared widths, command codes and helpers for the interrupt action dispatcher.
package int_action_dispatch_pkg;

    localparam int FUNC_WIDTH = 4;
    localparam int DATA_WIDTH = 32;

    // Layer controller functional IDs carried in the interrupt action table.
    localparam logic [FUNC_WIDTH-1:0] LC_CMD_RF_WRITE  = 4'h0;
    localparam logic [FUNC_WIDTH-1:0] LC_CMD_RF_READ   = 4'h1;
    localparam logic [FUNC_WIDTH-1:0] LC_CMD_MEM_WRITE = 4'h2;
    localparam logic [FUNC_WIDTH-1:0] LC_CMD_MEM_READ  = 4'h3;

    // Word k of a three-word payload; word 0 is the most significant slice.
    function automatic logic [DATA_WIDTH-1:0] payload_word(
        input logic [3*DATA_WIDTH-1:0] payload,
        input logic [1:0]              k
    );
        case (k)
            2'd0:    return payload[3*DATA_WIDTH-1:2*DATA_WIDTH];
            2'd1:    return payload[2*DATA_WIDTH-1:DATA_WIDTH];
            default: return payload[DATA_WIDTH-1:0];
        endcase
    endfunction

endpackage

// File: rtl/int_action_dispatch_if.sv
// Command path from the dispatcher to the layer controller (valid/ack).
interface int_action_dispatch_if;
    import int_action_dispatch_pkg::*;

    logic [FUNC_WIDTH-1:0] INT_FU_ID;
    logic [DATA_WIDTH-1:0] INT_DATA;
    logic                  INT_DATA_VALID;
    logic                  INT_DATA_LAST;
    logic                  INT_DATA_ACK;

    modport master (
        output INT_FU_ID, INT_DATA, INT_DATA_VALID, INT_DATA_LAST,
        input  INT_DATA_ACK
    );

    modport slave (
        input  INT_FU_ID, INT_DATA, INT_DATA_VALID, INT_DATA_LAST,
        output INT_DATA_ACK
    );

endinterface

// File: rtl/int_action_dispatch_pri_encoder.sv
// Lowest-index-first priority encoder with an any-set flag.
module int_pri_encoder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan from the top down so the lowest set bit is written last and wins.
    always_comb begin
        // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
        o_idx = '0;
        o_any = |i_req;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/int_action_dispatch.sv
// Interrupt action dispatcher: arbitrates requests, latches the table entry,
// streams its command words over valid/ack and pulses the request clear.
module int_action_dispatch
    import int_action_dispatch_pkg::*;
#(
    parameter int LC_INT_DEPTH = 8
) (
    input  logic                                 CLK,
    input  logic                                 RESET,
    input  logic [LC_INT_DEPTH-1:0]              REQ_INT,
    input  logic [FUNC_WIDTH*LC_INT_DEPTH-1:0]   INT_FUNC_ID,
    input  logic [3*DATA_WIDTH*LC_INT_DEPTH-1:0] INT_PAYLOAD,
    input  logic [2*LC_INT_DEPTH-1:0]            INT_CMD_LEN,
    output logic [LC_INT_DEPTH-1:0]              CLR_INT,
    output logic                                 WAKEUP_REQ,
    int_action_dispatch_if.master                cmd
);

    localparam int IW = (LC_INT_DEPTH > 1) ? $clog2(LC_INT_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CLR  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [FUNC_WIDTH-1:0]   r_func;
    logic [3*DATA_WIDTH-1:0] r_payload;
    logic [1:0]              r_len;
    logic [IW-1:0]           r_idx;
    logic [1:0]              r_k;
    logic [LC_INT_DEPTH-1:0] r_clr_int;
    logic                    r_wakeup;
    logic [FUNC_WIDTH-1:0]   r_fu_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;
    logic                    r_last;

    logic [IW-1:0]           w_idx;
    logic                    w_any;
    logic [FUNC_WIDTH-1:0]   w_func_arr    [LC_INT_DEPTH];
    logic [3*DATA_WIDTH-1:0] w_payload_arr [LC_INT_DEPTH];
    logic [1:0]              w_len_arr     [LC_INT_DEPTH];
    logic [FUNC_WIDTH-1:0]   w_sel_func;
    logic [3*DATA_WIDTH-1:0] w_sel_payload;
    logic [1:0]              w_sel_len;

    int_pri_encoder #(
        .WIDTH (LC_INT_DEPTH),
        .IDX_W (IW)
    ) u_pri_enc (
        .i_req (REQ_INT),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Unpack the flat table into per-entry views.
    for (genvar gi = 0; gi < LC_INT_DEPTH; gi++) begin : g_entry
        assign w_func_arr[gi]    = INT_FUNC_ID[FUNC_WIDTH*gi +: FUNC_WIDTH];
        assign w_payload_arr[gi] = INT_PAYLOAD[3*DATA_WIDTH*gi +: 3*DATA_WIDTH];
        assign w_len_arr[gi]     = INT_CMD_LEN[2*gi +: 2];
    end

    assign w_sel_func    = w_func_arr[w_idx];
    assign w_sel_payload = w_payload_arr[w_idx];
    assign w_sel_len     = w_len_arr[w_idx];

    function automatic logic [LC_INT_DEPTH-1:0] onehot(input logic [IW-1:0] idx);
        return LC_INT_DEPTH'(1) << idx;
    endfunction

    // Dispatcher FSM; every output is a register written here. WAKEUP_REQ
    // rises on acceptance and drops in the first IDLE cycle with nothing pending,
    // so it also covers the IDLE cycle that follows a clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            // NOTE: the single-entry latch is reset too, so a reset fully discards the entry in flight.
            r_state   <= ST_IDLE;
            r_func    <= '0;
            r_payload <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_k       <= '0;
            r_clr_int <= '0;
            r_wakeup  <= 1'b0;
            r_fu_id   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    r_clr_int <= '0;
                    r_wakeup  <= w_any;
                    if (w_any) begin
                        r_func    <= w_sel_func;
                        r_payload <= w_sel_payload;
                        r_len     <= w_sel_len;
                        r_idx     <= w_idx;
                        r_k       <= 2'd0;
                        if (w_sel_len != 2'd0) begin
                            r_state <= ST_SEND;
                            r_valid <= 1'b1;
                            r_fu_id <= w_sel_func;
                            r_data  <= payload_word(w_sel_payload, 2'd0);
                            r_last  <= (w_sel_len == 2'd1);
                        end else begin
                            r_state   <= ST_CLR;
                            r_clr_int <= onehot(w_idx);
                        end
                    end
                end
                ST_SEND: begin
                    if (cmd.INT_DATA_ACK) begin
                        r_k <= r_k + 2'd1;
                        if (r_last) begin
                            r_state   <= ST_CLR;
                            r_valid   <= 1'b0;
                            r_last    <= 1'b0;
                            r_data    <= '0;
                            r_fu_id   <= '0;
                            r_clr_int <= onehot(r_idx);
                        end else begin
                            r_data <= payload_word(r_payload, r_k + 2'd1);
                            r_last <= ((r_k + 2'd1) == (r_len - 2'd1));
                        end
                    end
                end
                ST_CLR: begin
                    r_clr_int <= '0;
                    r_k       <= 2'd0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign CLR_INT            = r_clr_int;
    assign WAKEUP_REQ         = r_wakeup;
    assign cmd.INT_FU_ID      = r_fu_id;
    assign cmd.INT_DATA       = r_data;
    assign cmd.INT_DATA_VALID = r_valid;
    assign cmd.INT_DATA_LAST  = r_last;

endmodule

// File: tb/tb_int_action_dispatch.sv
// Directed self-checking bench for int_action_dispatch.
module tb_int_action_dispatch;
    import int_action_dispatch_pkg::*;

    localparam int N  = 8;
    localparam int DW = DATA_WIDTH;
    localparam int FW = FUNC_WIDTH;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic [N-1:0]      req_int = '0;
    logic [FW*N-1:0]   func_id = '0;
    logic [3*DW*N-1:0] payload = '0;
    logic [2*N-1:0]    cmd_len = '0;
    logic [N-1:0]      clr_int;
    logic              wakeup_req;

    int checks   = 0;
    int failures = 0;

    int_action_dispatch_if u_if ();

    int_action_dispatch #(.LC_INT_DEPTH(N)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .REQ_INT     (req_int),
        .INT_FUNC_ID (func_id),
        .INT_PAYLOAD (payload),
        .INT_CMD_LEN (cmd_len),
        .CLR_INT     (clr_int),
        .WAKEUP_REQ  (wakeup_req),
        .cmd         (u_if.master)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_entry(input int i, input logic [FW-1:0] f, input logic [DW-1:0] w0,
                             input logic [DW-1:0] w1, input logic [DW-1:0] w2, input logic [1:0] len);
        func_id[FW*i +: FW]     = f;
        payload[3*DW*i +: 3*DW] = {w0, w1, w2};
        cmd_len[2*i +: 2]       = len;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_clr"},   32'(clr_int), 32'h0);
        check({tag, "_fu"},    32'(u_if.INT_FU_ID), 32'h0);
        check({tag, "_data"},  u_if.INT_DATA, 32'h0);
        check({tag, "_valid"}, 32'(u_if.INT_DATA_VALID), 32'h0);
        check({tag, "_last"},  32'(u_if.INT_DATA_LAST), 32'h0);
        check({tag, "_wake"},  32'(wakeup_req), 32'h0);
    endtask

    initial begin
        int valid_cnt;
        int wake_cnt;
        int clr_cnt;
        logic [N-1:0] clr_seen;

        u_if.INT_DATA_ACK = 1'b1;

        // ---- Reset with every request pending; entry 0 goes first after release.
        set_entry(0, LC_CMD_RF_READ, 32'h0000_2200, 32'h0, 32'h0, 2'd1);
        req_int = 8'hFF;
        step();
        step();
        check_all_zero("rst");
        RESET = 1'b0;
        step();
        check("single_valid", 32'(u_if.INT_DATA_VALID), 32'h1);
        check("single_data",  u_if.INT_DATA, 32'h0000_2200);
        check("single_last",  32'(u_if.INT_DATA_LAST), 32'h1);
        check("single_fu",    32'(u_if.INT_FU_ID), 32'(LC_CMD_RF_READ));
        check("single_wake",  32'(wakeup_req), 32'h1);
        step();
        check("single_clr",    32'(clr_int), 32'h01);
        check("single_valid0", 32'(u_if.INT_DATA_VALID), 32'h0);
        req_int = 8'h00;
        step();
        check("single_clr_done", 32'(clr_int), 32'h00);
        check("single_wake_hold", 32'(wakeup_req), 32'h1);
        step();
        check("single_wake_drop", 32'(wakeup_req), 32'h0);

        // ---- Three words on entry 6 with two stall cycles on word 1.
        set_entry(6, LC_CMD_MEM_WRITE, 32'h0212_3321, 32'h04ab_ccba, 32'h0609_0785, 2'd3);
        req_int = 8'h40;
        step();
        check("w3_k0_data",  u_if.INT_DATA, 32'h0212_3321);
        check("w3_k0_last",  32'(u_if.INT_DATA_LAST), 32'h0);
        check("w3_k0_fu",    32'(u_if.INT_FU_ID), 32'(LC_CMD_MEM_WRITE));
        step();
        check("w3_k1_data",  u_if.INT_DATA, 32'h04ab_ccba);
        check("w3_k1_last",  32'(u_if.INT_DATA_LAST), 32'h0);
        u_if.INT_DATA_ACK = 1'b0;
        // Table edits after acceptance must not reach the command in flight.
        set_entry(6, LC_CMD_RF_WRITE, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 2'd1);
        step();
        check("w3_stall1_data",  u_if.INT_DATA, 32'h04ab_ccba);
        check("w3_stall1_valid", 32'(u_if.INT_DATA_VALID), 32'h1);
        check("w3_stall1_last",  32'(u_if.INT_DATA_LAST), 32'h0);
        step();
        check("w3_stall2_data",  u_if.INT_DATA, 32'h04ab_ccba);
        check("w3_stall2_fu",    32'(u_if.INT_FU_ID), 32'(LC_CMD_MEM_WRITE));
        u_if.INT_DATA_ACK = 1'b1;
        step();
        check("w3_k2_data",  u_if.INT_DATA, 32'h0609_0785);
        check("w3_k2_last",  32'(u_if.INT_DATA_LAST), 32'h1);
        step();
        check("w3_clr",      32'(clr_int), 32'h40);
        check("w3_valid0",   32'(u_if.INT_DATA_VALID), 32'h0);
        req_int = 8'h00;
        step();
        check("w3_clr_done", 32'(clr_int), 32'h00);
        step();

        // ---- Arbitration: 5 before 7, no preemption.
        set_entry(5, LC_CMD_RF_WRITE, 32'h5555_0005, 32'h0, 32'h0, 2'd1);
        set_entry(7, LC_CMD_MEM_READ, 32'h7777_0007, 32'h0, 32'h0, 2'd1);
        req_int = 8'b1010_0000;
        step();
        check("arb_first_data", u_if.INT_DATA, 32'h5555_0005);
        check("arb_first_fu",   32'(u_if.INT_FU_ID), 32'(LC_CMD_RF_WRITE));
        step();
        check("arb_first_clr",  32'(clr_int), 32'h20);
        req_int = 8'b1000_0000;
        step();
        check("arb_gap_valid",  32'(u_if.INT_DATA_VALID), 32'h0);
        step();
        check("arb_second_data", u_if.INT_DATA, 32'h7777_0007);
        check("arb_second_fu",   32'(u_if.INT_FU_ID), 32'(LC_CMD_MEM_READ));
        step();
        check("arb_second_clr", 32'(clr_int), 32'h80);
        req_int = 8'h00;
        step();
        step();
        check("arb_wake_drop",  32'(wakeup_req), 32'h0);

        // ---- Wake-only entry 7.
        set_entry(7, LC_CMD_RF_READ, 32'h1, 32'h2, 32'h3, 2'd0);
        req_int   = 8'h80;
        valid_cnt = 0;
        wake_cnt  = 0;
        clr_cnt   = 0;
        clr_seen  = '0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (u_if.INT_DATA_VALID) valid_cnt++;
            if (wakeup_req) wake_cnt++;
            if (clr_int != '0) clr_cnt++;
            clr_seen = clr_seen | clr_int;
            if (clr_int[7]) req_int[7] = 1'b0;
        end
        check("wake_valid_cycles", 32'(valid_cnt), 32'd0);
        check("wake_high_cycles",  32'(wake_cnt), 32'd2);
        check("wake_clr_cycles",   32'(clr_cnt), 32'd1);
        check("wake_clr_value",    32'(clr_seen), 32'h80);

        // ---- Reset in the middle of a three-word command.
        set_entry(2, LC_CMD_MEM_WRITE, 32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 2'd3);
        req_int = 8'h04;
        step();
        check("mid_k0_data", u_if.INT_DATA, 32'hA0A0_0000);
        step();
        check("mid_k1_data", u_if.INT_DATA, 32'hA1A1_1111);
        u_if.INT_DATA_ACK = 1'b0;
        #2;
        RESET = 1'b1;
        #1;
        check_all_zero("mid_rst");
        clr_seen = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            clr_seen = clr_seen | clr_int;
        end
        check("mid_rst_no_clr", 32'(clr_seen), 32'h0);
        RESET = 1'b0;
        u_if.INT_DATA_ACK = 1'b1;
        step();
        check("mid_restart_data", u_if.INT_DATA, 32'hA0A0_0000);
        check("mid_restart_last", 32'(u_if.INT_DATA_LAST), 32'h0);
        step();
        step();
        step();
        check("mid_restart_clr", 32'(clr_int), 32'h04);
        req_int = 8'h00;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
